// File: rtl/cache_arb_pkg.sv
// Shared types and width defaults for the I/D cache memory arbiter.
package cache_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

endpackage

// File: rtl/cache_arbiter_pick.sv
// Combinational grant selector: picks icache or dcache from the raw requests.
module arb_pick
    import cache_arb_pkg::*;
(
    input  logic    i_read,
    input  logic    d_read,
    input  logic    d_write,
    input  req_id_e last_served,
    output req_id_e grant_id,
    output logic    grant_valid
);

    logic d_valid;

    // A dcache request asking for both read and writeback at once is dropped.
    assign d_valid = d_read ^ d_write;

    always_comb begin
        grant_valid = i_read | d_valid;
        grant_id    = REQ_D;
        if (i_read && d_valid) begin
            grant_id = (last_served == REQ_D) ? REQ_I : REQ_D;
        end else if (i_read) begin
            grant_id = REQ_I;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates icache line reads and dcache reads/writebacks onto one memory adaptor.
// Define CACHE_ARB_RR_EN for round-robin on simultaneous requests; default is dcache priority.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output arb_state_e        dbg_state
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    req_id_e           last_served;
    req_id_e           grant_id;
    logic              grant_valid;

    arb_pick u_pick (
        .i_read      (i_read),
        .d_read      (d_read),
        .d_write     (d_write),
        .last_served (last_served),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

`ifdef CACHE_ARB_RR_EN
    req_id_e last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && grant_valid) begin
            last_d = grant_id;
        end
    end

    // Reset value REQ_I makes the dcache win the first simultaneous request.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_I;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_served = last_q;
`else
    // Pinning last_served to REQ_I turns the selector into fixed dcache priority.
    assign last_served = REQ_I;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_id == REQ_D) begin
                        state_d     = D_BUSY;
                        addr_d      = d_addr;
                        wdata_d     = d_wdata;
                        mem_read_d  = d_read;
                        mem_write_d = d_write;
                    end else begin
                        state_d     = I_BUSY;
                        addr_d      = i_addr;
                        wdata_d     = '0;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // A completion arriving while reset is asserted is discarded.
    assign i_resp    = !rst && mem_resp && (state_q == I_BUSY);
    assign d_resp    = !rst && mem_resp && (state_q == D_BUSY);
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign dbg_state = state_q;

endmodule
